sfp_accum_ctrl: RTL and testbench

Sequencer that drains the output FIFO row by row and applies the per-lane SFP function to each row: accumulate, ReLU or passthrough. Each result is written back to the PSUM SRAM. For each row it reads the stored partial sum, combines it across col lanes with the popped OFIFO row, and writes the result to the same address. It sits between the OFIFO (upstream) and the single-port PSUM SRAM (downstream), and is started by the core controller once per output tile.

---
 rtl/sfp_accum_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_sfp_accum_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_accum_ctrl.sv
// -----------------------------------------------------------------------------
// sfp_accum_ctrl
//   Drains the output FIFO one row at a time and writes each row back to the
//   single-port PSUM SRAM after applying the per-lane SFP function selected by
//   mode = {passthrough, accum, relu}:
//     - FETCH/WRITE (accum and/or relu): read the stored partial sum while
//       popping the OFIFO head into a hold register, then write
//       f(psum, hold) back to the same address. Two cycles per row.
//     - PASS: write the OFIFO head row unchanged. One cycle per row.
//   The SRAM is never read and written in the same cycle.
//
// Optional feature macro: SFP_SAT_EN
//   Defined   : the accumulate add saturates to the signed lane range; ReLU
//               (when selected) is applied after saturation.
//   Undefined : the accumulate add wraps modulo 2^psum_bw.
//
// Ports
//   clk         clock
//   reset       synchronous, active-high reset
//   start       one-cycle request, only honoured in IDLE
//   len         number of rows to process (latched at start)
//   base_addr   first SRAM address (latched at start)
//   mode        {passthrough, accum, relu} (latched at start)
//   ofifo_out   show-ahead OFIFO head row, lane i = bits [psum_bw*(i+1)-1 -: psum_bw]
//   ofifo_valid OFIFO head row valid
//   ofifo_rd    pop the OFIFO at this clock edge
//   psum_rdata  SRAM Q, valid the cycle after a read access
//   sram_cen    SRAM chip enable, active low
//   sram_wen    SRAM write enable, active low (1 = read)
//   sram_addr   SRAM address
//   sram_wdata  SRAM D
//   busy        high in every state except IDLE
//   done        one-cycle completion pulse
// -----------------------------------------------------------------------------
module sfp_accum_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int addr_bw = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       len,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic [2:0]               mode,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  input  logic                     ofifo_valid,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   psum_rdata,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_wdata,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = col * psum_bw;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_PASS  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state, w_state_n;
  logic [addr_bw-1:0]   r_idx, w_idx_n;
  logic [addr_bw-1:0]   r_len, w_len_n;
  logic [addr_bw-1:0]   r_base, w_base_n;
  // Only {accum, relu} are kept: passthrough is carried by the PASS state.
  logic [1:0]           r_mode, w_mode_n;
  logic [ROW_W-1:0]     r_hold, w_hold_n;

  logic [addr_bw-1:0]   w_addr;
  logic                 w_last;
  logic [ROW_W-1:0]     w_sfp;

  // Lane add: saturating or wrapping depending on the build.
  function automatic logic signed [psum_bw-1:0] lane_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
`ifdef SFP_SAT_EN
    logic signed [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    // Overflow when the carry-out sign disagrees with the lane sign bit.
    if (s[psum_bw] != s[psum_bw-1])
      return s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    return s[psum_bw-1:0];
`else
    return a + b;
`endif
  endfunction

  function automatic logic signed [psum_bw-1:0] lane_relu(
    input logic signed [psum_bw-1:0] x,
    input logic                      en
  );
    return (en && x[psum_bw-1]) ? '0 : x;
  endfunction

  function automatic logic signed [psum_bw-1:0] lane_sfp(
    input logic signed [psum_bw-1:0] p,
    input logic signed [psum_bw-1:0] h,
    input logic                      acc,
    input logic                      rl
  );
    logic signed [psum_bw-1:0] v;
    v = acc ? lane_add(p, h) : p;
    return lane_relu(v, rl);
  endfunction

  assign w_addr = r_base + r_idx;
  assign w_last = (r_idx == r_len - addr_bw'(1));

  for (genvar g = 0; g < col; g++) begin : g_lane
    logic signed [psum_bw-1:0] w_p, w_h, w_r;
    assign w_p = psum_rdata[g*psum_bw +: psum_bw];
    assign w_h = r_hold[g*psum_bw +: psum_bw];
    assign w_r = lane_sfp(w_p, w_h, r_mode[1], r_mode[0]);
    assign w_sfp[g*psum_bw +: psum_bw] = w_r;
  end

  always_comb begin
    w_state_n  = r_state;
    w_idx_n    = r_idx;
    w_len_n    = r_len;
    w_base_n   = r_base;
    w_mode_n   = r_mode;
    w_hold_n   = r_hold;
    ofifo_rd   = 1'b0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_addr  = '0;
    sram_wdata = '0;
    busy       = 1'b1;
    done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_len_n  = len;
          w_base_n = base_addr;
          w_mode_n = mode[1:0];
          w_idx_n  = '0;
          if (len == '0)   w_state_n = S_DONE;
          else if (mode[2]) w_state_n = S_PASS;
          else              w_state_n = S_FETCH;
        end
      end

      S_FETCH: begin
        if (ofifo_valid) begin
          ofifo_rd  = 1'b1;
          sram_cen  = 1'b0;
          sram_addr = w_addr;
          w_hold_n  = ofifo_out;
          w_state_n = S_WRITE;
        end
      end

      S_WRITE: begin
        sram_cen   = 1'b0;
        sram_wen   = 1'b0;
        sram_addr  = w_addr;
        sram_wdata = w_sfp;
        if (w_last) begin
          w_state_n = S_DONE;
        end else begin
          w_idx_n   = r_idx + addr_bw'(1);
          w_state_n = S_FETCH;
        end
      end

      S_PASS: begin
        if (ofifo_valid) begin
          ofifo_rd   = 1'b1;
          sram_cen   = 1'b0;
          sram_wen   = 1'b0;
          sram_addr  = w_addr;
          sram_wdata = ofifo_out;
          if (w_last) w_state_n = S_DONE;
          else        w_idx_n   = r_idx + addr_bw'(1);
        end
      end

      S_DONE: begin
        done      = 1'b1;
        w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase

    // A reset cycle must not commit a write or a pop at its closing edge.
    if (reset) begin
      ofifo_rd = 1'b0;
      sram_cen = 1'b1;
      sram_wen = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_base  <= '0;
      r_mode  <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_len   <= w_len_n;
      r_base  <= w_base_n;
      r_mode  <= w_mode_n;
      r_hold  <= w_hold_n;
    end
  end

endmodule

// File: tb/tb_sfp_accum_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for sfp_accum_ctrl: SRAM and OFIFO environment models, a
// transaction-level reference model of the expected SRAM access trace, and a
// linear sequence of directed and randomized operations.
// -----------------------------------------------------------------------------
module tb_sfp_accum_ctrl;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int AW  = 11;
  localparam int RW  = COL * PW;
  localparam int DEPTH = 2048;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [AW-1:0] len, base_addr;
  logic [2:0]    mode;
  logic [RW-1:0] ofifo_out, psum_rdata, sram_wdata;
  logic          ofifo_valid, ofifo_rd, sram_cen, sram_wen, busy, done;
  logic [AW-1:0] sram_addr;

  always #5 clk = ~clk;

  sfp_accum_ctrl #(.col(COL), .psum_bw(PW), .addr_bw(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .len        (len),
    .base_addr  (base_addr),
    .mode       (mode),
    .ofifo_out  (ofifo_out),
    .ofifo_valid(ofifo_valid),
    .ofifo_rd   (ofifo_rd),
    .psum_rdata (psum_rdata),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .done       (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM environment: one access per cycle, Q registered, plus a bench load port.
  logic [RW-1:0] mem [0:DEPTH-1];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [RW-1:0] ld_data;
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (!sram_cen) begin
      if (!sram_wen) mem[sram_addr] <= sram_wdata;
      else           psum_rdata     <= mem[sram_addr];
    end
  end

  // OFIFO environment: show-ahead head row, optional one-cycle valid gap.
  logic [RW-1:0] fifo_rows [0:15];
  int pops = 0, fifo_base = 0, fifo_n = 0, gap_abs = -1;
  int fifo_idx;
  always @(posedge clk) if (ofifo_rd) pops <= pops + 1;
  always_comb begin
    fifo_idx    = pops - fifo_base;
    ofifo_valid = (fifo_idx >= 0) && (fifo_idx < fifo_n) && (cyc != gap_abs);
    ofifo_out   = '0;
    if (fifo_idx >= 0 && fifo_idx < 16) ofifo_out = fifo_rows[fifo_idx[3:0]];
  end

  // Access log sampled mid-cycle.
  int            log_cyc[$];
  bit            log_we[$];
  logic [AW-1:0] log_addr[$];
  logic [RW-1:0] log_data[$];
  always @(negedge clk) begin
    if (!sram_cen) begin
      log_cyc.push_back(cyc);
      log_we.push_back(!sram_wen);
      log_addr.push_back(sram_addr);
      log_data.push_back(sram_wdata);
    end
  end

  // Reference model state and expected trace.
  logic [RW-1:0] ref_mem [0:DEPTH-1];
  int            ex_cyc[$];
  bit            ex_we[$];
  logic [AW-1:0] ex_addr[$];
  logic [RW-1:0] ex_data[$];
  int            ex_done, ex_pops;
  int            last_l0, last_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lane_f(input int p, input int h, input bit acc, input bit rl);
    int s;
    s = p;
    if (acc) begin
      s = p + h;
`ifdef SFP_SAT_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`else
      if (s > 32767)  s = s - 65536;
      if (s < -32768) s = s + 65536;
`endif
    end
    if (rl && s < 0) s = 0;
    return s;
  endfunction

  function automatic logic [RW-1:0] row_f(input logic [RW-1:0] p, input logic [RW-1:0] h,
                                          input bit acc, input bit rl);
    logic [RW-1:0] r;
    logic [PW-1:0] lp, lh;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      lp = p[i*PW +: PW];
      lh = h[i*PW +: PW];
      v  = lane_f(int'($signed(lp)), int'($signed(lh)), acc, rl);
      r[i*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] row_all(input int v);
    logic [RW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*PW +: PW] = v[PW-1:0];
    return r;
  endfunction

  function automatic logic [RW-1:0] row_rand();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic preload(input int a, input logic [RW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_ex(input int c, input bit we, input int a, input logic [RW-1:0] d);
    ex_cyc.push_back(c);
    ex_we.push_back(we);
    ex_addr.push_back(AW'(a));
    ex_data.push_back(d);
  endtask

  // Expected trace in cycles relative to the start cycle: each row occupies
  // one cycle (PASS) or read-then-write (otherwise); the row fetch slips by
  // one cycle when it lands on the OFIFO gap.
  task automatic model_op(input logic [2:0] m, input int b, input int n, input int gap);
    int c, a;
    logic [RW-1:0] w;
    ex_cyc.delete(); ex_we.delete(); ex_addr.delete(); ex_data.delete();
    ex_pops = n;
    c = 1;
    for (int r = 0; r < n; r++) begin
      a = (b + r) % DEPTH;
      if (c == gap) c++;
      if (m[2]) begin
        push_ex(c, 1'b1, a, fifo_rows[r]);
        ref_mem[a] = fifo_rows[r];
        c += 1;
      end else begin
        push_ex(c, 1'b0, a, '0);
        w = row_f(ref_mem[a], fifo_rows[r], m[1], m[0]);
        push_ex(c + 1, 1'b1, a, w);
        ref_mem[a] = w;
        c += 2;
      end
    end
    ex_done = c;
  endtask

  task automatic run_op(input logic [2:0] m, input int b, input int n, input int gap);
    int t, l0, p0, dc, ne;
    bit got;
    fifo_base = pops;
    fifo_n    = n;
    model_op(m, b, n, gap);
    l0 = log_cyc.size();
    p0 = pops;
    t  = cyc;
    last_l0 = l0;
    last_t  = t;
    gap_abs = (gap > 0) ? t + gap : -1;
    start = 1'b1; len = AW'(n); base_addr = AW'(b); mode = m;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0; dc = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; dc = cyc; end
    end
    check("done_seen", got, 1);
    if (got) check("done_latency", dc - t, ex_done);
    @(posedge clk); #1;
    check("pop_count", pops - p0, ex_pops);
    check("access_count", log_cyc.size() - l0, ex_cyc.size());
    ne = ex_cyc.size();
    for (int i = 0; i < ne; i++) begin
      if (l0 + i < log_cyc.size()) begin
        check("acc_cycle", log_cyc[l0+i] - t, ex_cyc[i]);
        check("acc_is_write", log_we[l0+i], ex_we[i]);
        check("acc_addr", log_addr[l0+i], ex_addr[i]);
        if (ex_we[i]) check("acc_wdata", log_data[l0+i], ex_data[i]);
      end
    end
    gap_abs = -1;
  endtask

  initial begin
    int t, l0, nlate;
    logic [RW-1:0] keep, prow, hrow;
    logic [2:0] m;
    int b, n, g;

    reset = 1'b1; start = 1'b1; len = AW'(5); base_addr = '0; mode = 3'b000;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    for (int i = 0; i < 16; i++) fifo_rows[i] = '0;

    // Reset with start held high: start must be ignored.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_cen", sram_cen, 1);
    check("rst_wen", sram_wen, 1);
    check("rst_ofifo_rd", ofifo_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_start_ignored", busy, 0);
    @(posedge clk); #1;

    // accum+relu, base 5, len 2
    preload(5, row_all(10));
    preload(6, row_all(-20));
    fifo_rows[0] = row_all(3);
    fifo_rows[1] = row_all(3);
    run_op(3'b011, 5, 2, 0);
    check("ar_w5_data", log_data[last_l0+1], row_all(13));
    check("ar_w6_data", log_data[last_l0+3], row_all(0));
    check("ar_r6_addr", log_addr[last_l0+2], 6);

    // passthrough, len 3, valid gap after the first row
    for (int i = 0; i < 3; i++) fifo_rows[i] = row_rand();
    run_op(3'b100, 40, 3, 2);

    // accumulate overflow at both ends of the lane range
    prow = row_all(16'h1234);
    prow[0*PW +: PW] = 16'h7FFF;
    prow[1*PW +: PW] = 16'h8000;
    hrow = row_all(5);
    hrow[0*PW +: PW] = 16'h0001;
    hrow[1*PW +: PW] = 16'hFFFF;
    preload(7, prow);
    fifo_rows[0] = hrow;
    run_op(3'b010, 7, 1, 0);
`ifdef SFP_SAT_EN
    check("ovf_pos_lane", log_data[last_l0+1][0*PW +: PW], 16'h7FFF);
    check("ovf_neg_lane", log_data[last_l0+1][1*PW +: PW], 16'h8000);
`else
    check("ovf_pos_lane", log_data[last_l0+1][0*PW +: PW], 16'h8000);
    check("ovf_neg_lane", log_data[last_l0+1][1*PW +: PW], 16'h7FFF);
`endif

    // plain copy-back across the top of the address space
    preload(2046, row_rand());
    preload(2047, row_rand());
    preload(0, row_rand());
    for (int i = 0; i < 3; i++) fifo_rows[i] = row_rand();
    run_op(3'b000, 2046, 3, 0);
    check("wrap_addr2", log_addr[last_l0+4], 0);
    check("wrap_copy", log_data[last_l0+5], ref_mem[0]);

    // randomized operations
    for (int it = 0; it < 8; it++) begin
      m = 3'($urandom_range(0, 7));
      b = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 8);
      g = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
      for (int r = 0; r < n; r++) begin
        preload((b + r) % DEPTH, row_rand());
        fifo_rows[r] = row_rand();
      end
      run_op(m, b, n, g);
    end

    // reset while in WRITE
    keep = row_rand();
    preload(100, keep);
    preload(101, row_rand());
    preload(102, row_rand());
    for (int i = 0; i < 3; i++) fifo_rows[i] = row_rand();
    fifo_base = pops; fifo_n = 3;
    l0 = log_cyc.size();
    t  = cyc;
    start = 1'b1; len = AW'(3); base_addr = AW'(100); mode = 3'b010;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("rstw_no_write", sram_cen, 1);
    check("rstw_no_pop", ofifo_rd, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstw_busy", busy, 0);
    check("rstw_cen", sram_cen, 1);
    repeat (3) @(posedge clk);
    #1;
    nlate = 0;
    for (int i = l0; i < log_cyc.size(); i++) if (log_cyc[i] >= t + 2) nlate++;
    check("rstw_late_accesses", nlate, 0);
    check("rstw_accesses", log_cyc.size() - l0, 1);
    check("rstw_mem_kept", mem[100], keep);
    ref_mem[100] = keep;

    // zero-length request right after the reset
    run_op(3'b010, 9, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
